// File: rtl/antirrebote_pkg.sv
// Shared types and default constants for the push-button debouncer.
package antirrebote_pkg;

    // Debouncer FSM states.
    typedef enum logic [2:0] {
        SOLTADO      = 3'd0,
        CONF_PRESION = 3'd1,
        PRESIONADO   = 3'd2,
        REPITIENDO   = 3'd3,
        CONF_SUELTA  = 3'd4
    } estado_boton_t;

    // Default timing: 10 ms debounce, 500 ms to first repeat, 100 ms between repeats at 50 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
    localparam bit          DEF_REPEAT_EN       = 1'b1;
    localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;

    // Largest of three counts; sizes the shared counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages clear on reset.
module sincronizador_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the raw bit through two flops to resolve metastability.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/antirrebote_boton.sv
// Push-button debouncer: one-cycle advance pulse per accepted press, optional
// hold-to-repeat, and a registered debounced level.
module antirrebote_boton
    import antirrebote_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = DEF_REPEAT_EN,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic boton_in,
    output logic pulso_out,
    output logic nivel_estable
);

    localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic          s;
    estado_boton_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic          pulso_reg, pulso_next;
    logic          nivel_reg, nivel_next;

    sincronizador_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (boton_in),
        .q     (s)
    );

    // State, shared counter and both outputs are registered together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= SOLTADO;
            cnt_reg   <= '0;
            pulso_reg <= 1'b0;
            nivel_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pulso_reg <= pulso_next;
            nivel_reg <= nivel_next;
        end
    end

    // Next-state logic; the pulse defaults low so it can never last two cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulso_next = 1'b0;
        nivel_next = nivel_reg;
        case (state_reg)
            SOLTADO: begin
                if (s) begin
                    cnt_next   = '0;
                    state_next = CONF_PRESION;
                end
            end
            CONF_PRESION: begin
                if (!s) begin
                    state_next = SOLTADO;
                end else if (cnt_reg == DEB_LAST) begin
                    cnt_next   = '0;
                    state_next = PRESIONADO;
                    nivel_next = 1'b1;
                    pulso_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            PRESIONADO: begin
                if (!s) begin
                    cnt_next   = '0;
                    state_next = CONF_SUELTA;
                end else if (cnt_reg == DLY_LAST) begin
                    // Without repeat the counter parks here instead of wrapping.
                    if (REPEAT_EN) begin
                        pulso_next = 1'b1;
                        cnt_next   = '0;
                        state_next = REPITIENDO;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            REPITIENDO: begin
                if (!s) begin
                    cnt_next   = '0;
                    state_next = CONF_SUELTA;
                end else if (cnt_reg == PER_LAST) begin
                    pulso_next = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            CONF_SUELTA: begin
                if (s) begin
                    // Release bounce: stay pressed, no pulse, repeat delay restarts.
                    cnt_next   = '0;
                    state_next = PRESIONADO;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = SOLTADO;
                    nivel_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = SOLTADO;
                cnt_next   = '0;
            end
        endcase
    end

    assign pulso_out     = pulso_reg;
    assign nivel_estable = nivel_reg;

endmodule
